// File: rtl/instr_dispatch_queue.sv
// In-order instruction dispatch FIFO: buffers control-unit pushes and issues the
// head entry to the arithmetic, load/store or RAM unit over valid/ready.
module instr_dispatch_queue #(
    parameter int unsigned LOG_DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 queue_we,
    input  logic [1:0]           queue_instr_type,
    input  logic [13:0]          queue_arith_instr,
    input  logic [8:0]           queue_ram_instr,
    input  logic [9:0]           queue_ld_st_instr,
    input  logic [17:0]          cache_addr,
    input  logic [17:0]          main_mem_addr,
    input  logic                 program_complete,
    output logic                 queue_full,
    output logic [LOG_DEPTH:0]   queue_count,
    output logic                 arith_valid,
    input  logic                 arith_ready,
    output logic [13:0]          arith_instr,
    output logic                 ld_st_valid,
    input  logic                 ld_st_ready,
    output logic [9:0]           ld_st_instr,
    output logic [17:0]          ld_st_cache_addr,
    output logic                 ram_valid,
    input  logic                 ram_ready,
    output logic [8:0]           ram_instr,
    output logic [17:0]          ram_cache_addr,
    output logic [17:0]          ram_main_mem_addr,
    output logic                 drained,
    output logic                 queue_error
);

    localparam int unsigned DEPTH = 1 << LOG_DEPTH;
    localparam int unsigned CW    = LOG_DEPTH + 1;
    localparam int unsigned PW    = 14;
    localparam int unsigned AW    = 18;

    localparam logic [1:0] INSTR_TYPE_ARITH = 2'd0;
    localparam logic [1:0] INSTR_TYPE_LD_ST = 2'd1;
    localparam logic [1:0] INSTR_TYPE_RAM   = 2'd2;
    localparam logic [1:0] INSTR_TYPE_LOOP  = 2'd3;

    logic [1:0]    type_mem  [DEPTH];
    logic [PW-1:0] pl_mem    [DEPTH];
    logic [AW-1:0] caddr_mem [DEPTH];
    logic [AW-1:0] maddr_mem [DEPTH];

    logic [LOG_DEPTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 drained_q, drained_d;

    logic          full, not_empty, push_ok, pop;
    logic [PW-1:0] push_payload;
    logic [1:0]    head_type;
    logic [PW-1:0] head_payload;
    logic [AW-1:0] head_caddr, head_maddr;

    assign full      = (count_q == CW'(DEPTH));
    assign not_empty = (count_q != '0);

    assign head_type    = type_mem[head_q];
    assign head_payload = pl_mem[head_q];
    assign head_caddr   = caddr_mem[head_q];
    assign head_maddr   = maddr_mem[head_q];

    assign arith_valid = not_empty && (head_type == INSTR_TYPE_ARITH);
    assign ld_st_valid = not_empty && (head_type == INSTR_TYPE_LD_ST);
    assign ram_valid   = not_empty && (head_type == INSTR_TYPE_RAM);

    assign pop     = (arith_valid && arith_ready) || (ld_st_valid && ld_st_ready) ||
                     (ram_valid && ram_ready);
    // full is the registered count, so a same-cycle pop never frees a slot
    assign push_ok = queue_we && !full && (queue_instr_type != INSTR_TYPE_LOOP);

    // Payloads are stored left-aligned in a common 14-bit field
    always_comb begin
        push_payload = '0;
        case (queue_instr_type)
            INSTR_TYPE_ARITH: push_payload = queue_arith_instr;
            INSTR_TYPE_LD_ST: push_payload = {queue_ld_st_instr, 4'b0000};
            INSTR_TYPE_RAM:   push_payload = {queue_ram_instr, 5'b00000};
            default:          push_payload = '0;
        endcase
    end

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        done_d    = done_q | program_complete;
        err_d     = err_q;
        drained_d = done_q && !not_empty;
        if (push_ok) tail_d = tail_q + LOG_DEPTH'(1);
        if (pop)     head_d = head_q + LOG_DEPTH'(1);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (queue_we && (full || (queue_instr_type == INSTR_TYPE_LOOP) || done_q))
            err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            drained_q <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            done_q    <= done_d;
            err_q     <= err_d;
            drained_q <= drained_d;
        end
    end

    // Entry storage carries no reset; occupancy is governed by the pointers
    always_ff @(posedge clk) begin
        if (push_ok) begin
            type_mem[tail_q]  <= queue_instr_type;
            pl_mem[tail_q]    <= push_payload;
            caddr_mem[tail_q] <= cache_addr;
            maddr_mem[tail_q] <= main_mem_addr;
        end
    end

    assign queue_full        = full;
    assign queue_count       = count_q;
    assign arith_instr       = head_payload;
    assign ld_st_instr       = head_payload[PW-1 -: 10];
    assign ld_st_cache_addr  = head_caddr;
    assign ram_instr         = head_payload[PW-1 -: 9];
    assign ram_cache_addr    = head_caddr;
    assign ram_main_mem_addr = head_maddr;
    assign drained           = drained_q;
    assign queue_error       = err_q;

endmodule

// File: tb/tb_instr_dispatch_queue.sv
// Self-checking bench for instr_dispatch_queue: vector table plus hand sequences,
// with a cycle-level scoreboard model checking every output on each falling edge.
module tb_instr_dispatch_queue;

    localparam int unsigned LOG_DEPTH = 3;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned CW        = LOG_DEPTH + 1;

    localparam logic [1:0] T_ARITH = 2'd0;
    localparam logic [1:0] T_LDST  = 2'd1;
    localparam logic [1:0] T_RAM   = 2'd2;
    localparam logic [1:0] T_LOOP  = 2'd3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          queue_we = 1'b0;
    logic [1:0]    queue_instr_type = 2'd0;
    logic [13:0]   queue_arith_instr = '0;
    logic [8:0]    queue_ram_instr = '0;
    logic [9:0]    queue_ld_st_instr = '0;
    logic [17:0]   cache_addr = '0;
    logic [17:0]   main_mem_addr = '0;
    logic          program_complete = 1'b0;
    logic          queue_full;
    logic [CW-1:0] queue_count;
    logic          arith_valid, ld_st_valid, ram_valid;
    logic          arith_ready = 1'b0, ld_st_ready = 1'b0, ram_ready = 1'b0;
    logic [13:0]   arith_instr;
    logic [9:0]    ld_st_instr;
    logic [17:0]   ld_st_cache_addr;
    logic [8:0]    ram_instr;
    logic [17:0]   ram_cache_addr, ram_main_mem_addr;
    logic          drained, queue_error;

    instr_dispatch_queue #(.LOG_DEPTH(LOG_DEPTH)) dut (
        .clk(clk), .reset(reset), .queue_we(queue_we), .queue_instr_type(queue_instr_type),
        .queue_arith_instr(queue_arith_instr), .queue_ram_instr(queue_ram_instr),
        .queue_ld_st_instr(queue_ld_st_instr), .cache_addr(cache_addr),
        .main_mem_addr(main_mem_addr), .program_complete(program_complete),
        .queue_full(queue_full), .queue_count(queue_count),
        .arith_valid(arith_valid), .arith_ready(arith_ready), .arith_instr(arith_instr),
        .ld_st_valid(ld_st_valid), .ld_st_ready(ld_st_ready), .ld_st_instr(ld_st_instr),
        .ld_st_cache_addr(ld_st_cache_addr),
        .ram_valid(ram_valid), .ram_ready(ram_ready), .ram_instr(ram_instr),
        .ram_cache_addr(ram_cache_addr), .ram_main_mem_addr(ram_main_mem_addr),
        .drained(drained), .queue_error(queue_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  typ;
        logic [13:0] pl;
        logic [17:0] ca;
        logic [17:0] ma;
    } sb_t;

    typedef struct {
        logic          we;
        logic [1:0]    typ;
        logic [13:0]   pl;
        logic [17:0]   ca;
        logic [17:0]   ma;
        logic [2:0]    rdy;
        logic [CW-1:0] e_cnt;
        logic [2:0]    e_v;
    } vec_t;

    sb_t  sb[$];
    vec_t vecs[15];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic err_m = 1'b0, done_m = 1'b0, drained_m = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        queue_we = 1'b0;
    endtask

    task automatic set_rdy(input logic [2:0] r);
        {arith_ready, ld_st_ready, ram_ready} = r;
    endtask

    // Unselected payload fields carry junk so a wrong field select is visible
    task automatic drive_push(input logic [1:0] t, input logic [13:0] p,
                              input logic [17:0] ca, input logic [17:0] ma);
        queue_we          = 1'b1;
        queue_instr_type  = t;
        queue_arith_instr = 14'($urandom);
        queue_ld_st_instr = 10'($urandom);
        queue_ram_instr   = 9'($urandom);
        case (t)
            T_ARITH: queue_arith_instr = p;
            T_LDST:  queue_ld_st_instr = p[9:0];
            T_RAM:   queue_ram_instr   = p[8:0];
            default: ;
        endcase
        cache_addr    = ca;
        main_mem_addr = ma;
    endtask

    task automatic wait_empty(input int budget);
        int k = 0;
        while (queue_count != '0 && k < budget) begin
            tick();
            k++;
        end
        chk("empty_within_budget", 64'(queue_count == '0), 64'(1));
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] t, input logic [13:0] p,
                                input logic [17:0] ca, input logic [17:0] ma,
                                input logic [2:0] rdy, input logic [CW-1:0] c,
                                input logic [2:0] v);
        vec_t r;
        r.we = we; r.typ = t; r.pl = p; r.ca = ca; r.ma = ma;
        r.rdy = rdy; r.e_cnt = c; r.e_v = v;
        return r;
    endfunction

    // Reference model: compare current outputs, then advance to the next edge
    logic [2:0] m_ev;
    logic       m_fire;
    int         m_size;
    sb_t        m_e;
    always @(negedge clk) begin
        m_size = sb.size();
        chk("count", 64'(queue_count), 64'(m_size));
        chk("full", 64'(queue_full), 64'(m_size == DEPTH));
        chk("error", 64'(queue_error), 64'(err_m));
        chk("drained", 64'(drained), 64'(drained_m));
        m_ev   = 3'b000;
        m_fire = 1'b0;
        if (m_size > 0) begin
            m_e = sb[0];
            case (m_e.typ)
                T_ARITH: begin m_ev = 3'b100; m_fire = arith_ready; end
                T_LDST:  begin m_ev = 3'b010; m_fire = ld_st_ready; end
                default: begin m_ev = 3'b001; m_fire = ram_ready;   end
            endcase
        end
        chk("valids", 64'({arith_valid, ld_st_valid, ram_valid}), 64'(m_ev));
        if (m_fire) begin
            case (m_e.typ)
                T_ARITH: chk("arith_instr", 64'(arith_instr), 64'(m_e.pl));
                T_LDST: begin
                    chk("ld_st_instr", 64'(ld_st_instr), 64'(m_e.pl[9:0]));
                    chk("ld_st_cache_addr", 64'(ld_st_cache_addr), 64'(m_e.ca));
                end
                default: begin
                    chk("ram_instr", 64'(ram_instr), 64'(m_e.pl[8:0]));
                    chk("ram_cache_addr", 64'(ram_cache_addr), 64'(m_e.ca));
                    chk("ram_main_mem_addr", 64'(ram_main_mem_addr), 64'(m_e.ma));
                end
            endcase
            void'(sb.pop_front());
        end
        if (reset) begin
            sb.delete();
            err_m     = 1'b0;
            done_m    = 1'b0;
            drained_m = 1'b0;
        end else begin
            drained_m = done_m && (m_size == 0);
            if (queue_we && (m_size == DEPTH || queue_instr_type == T_LOOP || done_m))
                err_m = 1'b1;
            if (queue_we && m_size < DEPTH && queue_instr_type != T_LOOP) begin
                m_e.typ = queue_instr_type;
                case (queue_instr_type)
                    T_ARITH: m_e.pl = queue_arith_instr;
                    T_LDST:  m_e.pl = 14'(queue_ld_st_instr);
                    default: m_e.pl = 14'(queue_ram_instr);
                endcase
                m_e.ca = cache_addr;
                m_e.ma = main_mem_addr;
                sb.push_back(m_e);
            end
            done_m = done_m | program_complete;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single RAM issue, then a mixed burst held by backpressure and released
        vecs[0]  = mk(1'b1, T_RAM,   14'h004,  18'd0,  18'd3,  3'b001, 4'd0, 3'b000);
        vecs[1]  = mk(1'b0, T_RAM,   14'h000,  18'd0,  18'd0,  3'b001, 4'd1, 3'b001);
        vecs[2]  = mk(1'b0, T_RAM,   14'h000,  18'd0,  18'd0,  3'b001, 4'd0, 3'b000);
        vecs[3]  = mk(1'b1, T_RAM,   14'h011,  18'd5,  18'd6,  3'b000, 4'd0, 3'b000);
        vecs[4]  = mk(1'b1, T_LDST,  14'h000,  18'd7,  18'd0,  3'b000, 4'd1, 3'b001);
        vecs[5]  = mk(1'b1, T_ARITH, 14'h0000, 18'd8,  18'd0,  3'b000, 4'd2, 3'b001);
        vecs[6]  = mk(1'b1, T_LDST,  14'h0C0,  18'd9,  18'd0,  3'b000, 4'd3, 3'b001);
        vecs[7]  = mk(1'b1, T_RAM,   14'h1FF,  18'd10, 18'd11, 3'b000, 4'd4, 3'b001);
        vecs[8]  = mk(1'b0, T_RAM,   14'h000,  18'd0,  18'd0,  3'b100, 4'd5, 3'b001);
        vecs[9]  = mk(1'b0, T_RAM,   14'h000,  18'd0,  18'd0,  3'b111, 4'd5, 3'b001);
        vecs[10] = mk(1'b0, T_RAM,   14'h000,  18'd0,  18'd0,  3'b111, 4'd4, 3'b010);
        vecs[11] = mk(1'b0, T_RAM,   14'h000,  18'd0,  18'd0,  3'b111, 4'd3, 3'b100);
        vecs[12] = mk(1'b0, T_RAM,   14'h000,  18'd0,  18'd0,  3'b111, 4'd2, 3'b010);
        vecs[13] = mk(1'b0, T_RAM,   14'h000,  18'd0,  18'd0,  3'b111, 4'd1, 3'b001);
        vecs[14] = mk(1'b0, T_RAM,   14'h000,  18'd0,  18'd0,  3'b000, 4'd0, 3'b000);

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_count", 64'(queue_count), 64'(0));
        chk("rst_full", 64'(queue_full), 64'(0));
        chk("rst_valids", 64'({arith_valid, ld_st_valid, ram_valid}), 64'(0));
        chk("rst_error", 64'(queue_error), 64'(0));
        chk("rst_drained", 64'(drained), 64'(0));

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].we) drive_push(vecs[i].typ, vecs[i].pl, vecs[i].ca, vecs[i].ma);
            else            idle();
            set_rdy(vecs[i].rdy);
            #3;
            chk($sformatf("vec%0d_count", i), 64'(queue_count), 64'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_valids", i), 64'({arith_valid, ld_st_valid, ram_valid}),
                64'(vecs[i].e_v));
            tick();
        end

        // Fill to capacity, overflow push, then drain
        idle();
        set_rdy(3'b000);
        for (int i = 0; i < 8; i++) begin
            drive_push(2'(i % 3), 14'($urandom), 18'($urandom), 18'($urandom));
            tick();
        end
        idle();
        chk("fill_full", 64'(queue_full), 64'(1));
        chk("fill_count", 64'(queue_count), 64'(8));
        chk("fill_error_clear", 64'(queue_error), 64'(0));
        drive_push(T_ARITH, 14'h3ABC, 18'h1, 18'h2);
        tick();
        idle();
        chk("overflow_error", 64'(queue_error), 64'(1));
        chk("overflow_count", 64'(queue_count), 64'(8));
        set_rdy(3'b111);
        wait_empty(20);
        chk("drain_valids", 64'({arith_valid, ld_st_valid, ram_valid}), 64'(0));
        pulse_reset();
        chk("post_rst_error", 64'(queue_error), 64'(0));

        // Steady push/pop stream across pointer wrap
        set_rdy(3'b100);
        for (int i = 0; i < 20; i++) begin
            drive_push(T_ARITH, 14'($urandom), 18'($urandom), 18'($urandom));
            tick();
            chk($sformatf("stream%0d_count", i), 64'(queue_count), 64'(1));
        end
        idle();
        chk("stream_error", 64'(queue_error), 64'(0));
        tick();
        chk("stream_end_count", 64'(queue_count), 64'(0));

        // Drain detection with two entries pending, then push after completion
        set_rdy(3'b000);
        drive_push(T_ARITH, 14'h1111, 18'h10, 18'h20);
        tick();
        drive_push(T_ARITH, 14'h2222, 18'h11, 18'h21);
        tick();
        idle();
        program_complete = 1'b1;
        tick();
        program_complete = 1'b0;
        chk("done_pending_drained", 64'(drained), 64'(0));
        chk("done_pending_count", 64'(queue_count), 64'(2));
        tick();
        chk("done_pending_drained2", 64'(drained), 64'(0));
        set_rdy(3'b100);
        wait_empty(10);
        chk("drained_lag", 64'(drained), 64'(0));
        tick();
        chk("drained_set", 64'(drained), 64'(1));
        drive_push(T_ARITH, 14'h3333, 18'h12, 18'h22);
        tick();
        idle();
        chk("late_push_error", 64'(queue_error), 64'(1));
        chk("late_push_stored", 64'(queue_count), 64'(1));
        tick();
        chk("late_push_popped", 64'(queue_count), 64'(0));

        // Illegal type, then reset with entries queued
        pulse_reset();
        set_rdy(3'b000);
        drive_push(T_LOOP, 14'h2AAA, 18'h3, 18'h4);
        tick();
        idle();
        chk("loop_count", 64'(queue_count), 64'(0));
        chk("loop_error", 64'(queue_error), 64'(1));
        chk("loop_valids", 64'({arith_valid, ld_st_valid, ram_valid}), 64'(0));
        for (int i = 0; i < 4; i++) begin
            drive_push(2'(i % 3), 14'($urandom), 18'($urandom), 18'($urandom));
            tick();
        end
        idle();
        chk("pre_rst_count", 64'(queue_count), 64'(4));
        program_complete = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        program_complete = 1'b0;
        chk("mid_rst_count", 64'(queue_count), 64'(0));
        chk("mid_rst_valids", 64'({arith_valid, ld_st_valid, ram_valid}), 64'(0));
        chk("mid_rst_full", 64'(queue_full), 64'(0));
        chk("mid_rst_drained", 64'(drained), 64'(0));
        chk("mid_rst_error", 64'(queue_error), 64'(0));
        tick();
        chk("mid_rst_drained2", 64'(drained), 64'(0));
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_dispatch_queue.md
Name: instr_dispatch_queue

Overview:
- In-order instruction FIFO on the consumer side of the control unit's queue write port.
- Accepts one instruction per cycle on `queue_we`, together with its type, type-specific payload, and the APU-resolved cache and main memory addresses.
- Issues the head entry to the arithmetic, load/store or RAM functional unit over a valid/ready handshake.
- Provides backpressure, drain detection and a sticky error flag.

Parameters:
- LOG_DEPTH, 3, log2 of FIFO entries (depth 8).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- queue_we  in  1  push strobe from control unit
- queue_instr_type  in  2  INSTR_TYPE_* code from shared types
- queue_arith_instr  in  14  arithmetic payload [0:13]
- queue_ram_instr  in  9  RAM payload [0:8]
- queue_ld_st_instr  in  10  load/store payload [0:9]
- cache_addr  in  18  resolved cache address
- main_mem_addr  in  18  resolved main memory address
- program_complete  in  1  control unit finished issuing
- queue_full  out  1  count == 2^LOG_DEPTH; control unit must not push
- queue_count  out  LOG_DEPTH+1  occupancy
- arith_valid, arith_ready  out/in  1  arithmetic handshake
- arith_instr  out  14  head payload
- ld_st_valid, ld_st_ready  out/in  1  load/store handshake
- ld_st_instr  out  10  head payload
- ld_st_cache_addr  out  18  head cache address
- ram_valid, ram_ready  out/in  1  RAM handshake
- ram_instr  out  9  head payload
- ram_cache_addr, ram_main_mem_addr  out  18  head addresses
- drained  out  1  program complete and queue empty
- queue_error  out  1  sticky error

Behaviour:
- Entry storage: type(2), payload(14, left-aligned; narrower payloads zero-padded at LSB end), cache_addr(18), main_mem_addr(18). Payload is selected by type at push.
- Push:
  - `queue_we`=1 and not full → write at tail, tail++ (mod depth).
  - Entry is visible at head no earlier than the next cycle (1-cycle push-to-valid latency; no fall-through).
- Full:
  - `queue_full` reflects the registered count; push while full is dropped and sets `queue_error`.
  - A pop in the same cycle does NOT make room for a push.
- Issue:
  - Only the head entry is eligible; issue is strictly in order.
  - Exactly one of `arith_valid`/`ld_st_valid`/`ram_valid` is high, matching the head type, when non-empty; all are 0 when empty.
  - Payload and address outputs are driven from the head combinationally. Fields are undefined-but-stable when the matching valid is 0; the bench checks only under valid.
- Pop: valid && matching ready in a cycle → head++ at the edge. Ready on a non-matching unit has no effect. Valid and data hold until accepted.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- Push into an empty queue with ready already high: entry issues in the cycle after the push.
- Pointer wrap: modulo 2^LOG_DEPTH; count tracks occupancy 0..2^LOG_DEPTH.
- Illegal type: push with INSTR_TYPE_LOOP is dropped (not stored) and sets `queue_error`.
- Drain:
  - `program_complete` high in any cycle latches `done_seen`.
  - `drained` = `done_seen` && count==0, registered (high the cycle after both conditions hold).
  - A push after `done_seen` sets `queue_error`; it is still stored if legal and not full.
- Reset: pointers, count, `done_seen`, `queue_error` and `drained` cleared; all valids 0, `queue_full`=0, `queue_count`=0. Reset mid-operation discards all entries; outputs are at reset values the cycle after reset is sampled.

Test Plan:
- Single RAM push (type RAM, `ram_instr`=9'h004, `cache_addr`=0, `main_mem_addr`=3), `ram_ready`=1 → `ram_valid`=1 exactly one cycle starting push+1 with those values; `queue_count` 1→0; other valids 0.
- Sequence RAM, LD_ST(10'h000), ARITH(14'h0000), LD_ST(10'h300>>2 payload), RAM with all readies low → count=5, only `ram_valid`=1. Raise `arith_ready` only → no pop. Then raise all readies → units see entries in push order, one per cycle, over 5 cycles.
- Fill 8 entries, readies low → `queue_full`=1, count=8. 9th push → dropped, `queue_error`=1. Release → 8 issues, then empty.
- Steady stream: push each cycle with `arith_ready`=1 for 20 cycles across wrap → count stays 1, no loss, order preserved, `queue_error`=0.
- `program_complete` pulse with 2 entries pending → `drained`=0 until both pop, then 1 the next cycle. A subsequent push → `queue_error`=1.
- Push with INSTR_TYPE_LOOP → nothing stored, `queue_error`=1. Reset with 4 entries queued → next cycle count=0, all valids 0, `drained`=0, `queue_error`=0.
